bar_level_writer: RTL and testbench

Frame-synchronous producer of bar heights for the bar-graph renderer. The audio/spectrum side pushes per-band levels through a valid/ready handshake. The block keeps one working level per bar, with peak capture, optional peak hold and linear decay. Once per video frame, at the VGA vertical-sync boundary, it publishes a stable snapshot on `bar_y`, so the renderer never sees a mid-frame change.

---
 rtl/bar_level_writer.sv | 183 ++++++++++++++++++
 tb/tb_bar_level_writer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_level_writer.sv
// Per-bar level store with peak capture and linear decay, published once per VGA frame on VS fall.
// Define BAR_PEAK_HOLD_EN to hold each new peak for HOLD_FRAMES frames before it starts decaying.
module bar_level_writer #(
    parameter int unsigned NUM_BARS    = 10,
    parameter int unsigned LEVEL_W     = 10,
    parameter int unsigned MAX_LEVEL   = 479,
    parameter int unsigned DECAY_STEP  = 4,
    parameter int unsigned HOLD_FRAMES = 15,
    localparam int unsigned BAND_W     = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1
) (
    input  logic                        MAX10_CLK1_50,
    input  logic                        Reset,
    input  logic                        lvl_valid,
    output logic                        lvl_ready,
    input  logic [BAND_W-1:0]           lvl_band,
    input  logic [LEVEL_W-1:0]          lvl_value,
    input  logic                        VGA_VS,
    output logic [NUM_BARS*LEVEL_W-1:0] bar_y,
    output logic                        frame_tick,
    output logic                        bad_band
);

    localparam logic [LEVEL_W-1:0] LvlMax    = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] DecayStep = LEVEL_W'(DECAY_STEP);

    if ((64'(MAX_LEVEL) >= (64'd1 << LEVEL_W)) || (HOLD_FRAMES > 32'hFFFF) || (NUM_BARS == 0))
    begin : g_param_check
        $error("bar_level_writer: invalid parameter combination");
    end

    // Reset: asynchronous assert, release synchronised to the clock
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge MAX10_CLK1_50 or negedge Reset) begin
        if (!Reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // VS synchroniser plus history flop; idle-high reset avoids a spurious edge on release
    logic r_vs_s1;
    logic r_vs_s2;
    logic r_vs_hist;
    logic w_vs_fall;

    always_ff @(posedge MAX10_CLK1_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vs_s1   <= 1'b1;
            r_vs_s2   <= 1'b1;
            r_vs_hist <= 1'b1;
        end else begin
            r_vs_s1   <= VGA_VS;
            r_vs_s2   <= r_vs_s1;
            r_vs_hist <= r_vs_s2;
        end
    end

    assign w_vs_fall = r_vs_hist & ~r_vs_s2;

    // Ready drops exactly in the tick cycle so writes never collide with publish/decay
    logic r_tick;
    logic r_ready;
    logic r_bad;

    always_ff @(posedge MAX10_CLK1_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tick  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_tick  <= w_vs_fall;
            r_ready <= ~w_vs_fall;
        end
    end

    logic               w_accept;
    logic               w_band_ok;
    logic [LEVEL_W-1:0] w_wr_val;

    assign w_accept  = lvl_valid & r_ready;
    assign w_band_ok = (32'(lvl_band) < NUM_BARS);
    assign w_wr_val  = (32'(lvl_value) > MAX_LEVEL) ? LvlMax : lvl_value;

    always_ff @(posedge MAX10_CLK1_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bad <= 1'b0;
        end else if (w_accept && !w_band_ok) begin
            r_bad <= 1'b1;
        end
    end

    logic [LEVEL_W-1:0]  r_level   [NUM_BARS];
    logic [LEVEL_W-1:0]  w_decayed [NUM_BARS];
    logic [NUM_BARS-1:0] w_hit;
    logic [NUM_BARS-1:0] w_holding;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            w_decayed[i] = '0;
            w_hit[i]     = w_accept && w_band_ok && (32'(lvl_band) == 32'(i)) &&
                           (w_wr_val > r_level[i]);
            if (r_level[i] > DecayStep) begin
                w_decayed[i] = r_level[i] - DecayStep;
            end
        end
    end

`ifdef BAR_PEAK_HOLD_EN
    localparam int unsigned HoldW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_FRAMES);

    logic [HoldW-1:0] r_hold [NUM_BARS];

    always_ff @(posedge MAX10_CLK1_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BARS; i++) begin
                if (r_tick) begin
                    if (r_hold[i] != '0) begin
                        r_hold[i] <= r_hold[i] - 1'b1;
                    end
                end else if (w_hit[i]) begin
                    r_hold[i] <= HoldLoad;
                end
            end
        end
    end

    always_comb begin
        w_holding = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            w_holding[i] = (r_hold[i] != '0);
        end
    end
`else
    assign w_holding = '0;
`endif

    always_ff @(posedge MAX10_CLK1_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BARS; i++) begin
                if (r_tick) begin
                    if (!w_holding[i]) begin
                        r_level[i] <= w_decayed[i];
                    end
                end else if (w_hit[i]) begin
                    r_level[i] <= w_wr_val;
                end
            end
        end
    end

    // Snapshot takes the pre-decay level
    logic [NUM_BARS*LEVEL_W-1:0] r_bar_y;

    always_ff @(posedge MAX10_CLK1_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bar_y <= '0;
        end else if (r_tick) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                r_bar_y[i*LEVEL_W +: LEVEL_W] <= r_level[i];
            end
        end
    end

    assign lvl_ready  = r_ready;
    assign frame_tick = r_tick;
    assign bad_band   = r_bad;
    assign bar_y      = r_bar_y;

endmodule

// File: tb/tb_bar_level_writer.sv
// Self-checking bench for bar_level_writer: table-driven writes plus a scoreboard of frame snapshots.
// Honours BAR_PEAK_HOLD_EN the same way as the design.
module tb_bar_level_writer;

    localparam int NB = 10;
    localparam int LW = 10;

    logic           clk;
    logic           Reset;
    logic           lvl_valid;
    logic           lvl_ready;
    logic [3:0]     lvl_band;
    logic [LW-1:0]  lvl_value;
    logic           VGA_VS;
    logic [NB*LW-1:0] bar_y;
    logic           frame_tick;
    logic           bad_band;

    bar_level_writer dut (
        .MAX10_CLK1_50 (clk),
        .Reset         (Reset),
        .lvl_valid     (lvl_valid),
        .lvl_ready     (lvl_ready),
        .lvl_band      (lvl_band),
        .lvl_value     (lvl_value),
        .VGA_VS        (VGA_VS),
        .bar_y         (bar_y),
        .frame_tick    (frame_tick),
        .bad_band      (bad_band)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [LW-1:0]    m_level [NB];
    int               m_hold  [NB];
    logic [NB*LW-1:0] exp_q [$];
    logic [NB*LW-1:0] last_pub;

    typedef struct {
        logic [3:0]    band;
        logic [LW-1:0] value;
        int            chk_bar;
        logic [LW-1:0] exp_hold;
        logic [LW-1:0] exp_nohold;
    } vec_t;

    vec_t vecs [9];

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NB; i++) begin
            m_level[i] = '0;
            m_hold[i]  = 0;
        end
        last_pub = '0;
    endfunction

    function automatic void model_write(input int b, input int v);
        int vv;
        if (b >= NB) return;
        vv = (v > 479) ? 479 : v;
        if (vv > int'(m_level[b])) begin
            m_level[b] = LW'(vv);
            m_hold[b]  = 15;
        end
    endfunction

    function automatic logic [NB*LW-1:0] model_pack();
        logic [NB*LW-1:0] p;
        for (int i = 0; i < NB; i++) p[i*LW +: LW] = m_level[i];
        return p;
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < NB; i++) begin
`ifdef BAR_PEAK_HOLD_EN
            if (m_hold[i] != 0) begin
                m_hold[i]--;
                continue;
            end
`endif
            m_level[i] = (m_level[i] > 4) ? m_level[i] - 4 : '0;
        end
    endfunction

    // All tasks start and end 1 time unit after a rising edge
    task automatic do_write(input logic [3:0] b, input logic [LW-1:0] v);
        int n = 0;
        lvl_valid = 1'b1;
        lvl_band  = b;
        lvl_value = v;
        while (!lvl_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("write_accepted", lvl_ready, 1'b1);
        @(posedge clk); #1;
        lvl_valid = 1'b0;
        if (n < 20) model_write(int'(b), int'(v));
        check("bar_y_stable_between_frames", bar_y, last_pub);
    endtask

    task automatic do_frame(input bit chk_timing);
        int n = 0;
        bit seen = 0;
        logic [NB*LW-1:0] exp;
        exp_q.push_back(model_pack());
        model_tick();
        VGA_VS = 1'b0;
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            seen = frame_tick;
        end
        check("frame_tick_seen", seen, 1'b1);
        exp = exp_q.pop_front();
        if (seen) begin
            if (chk_timing) begin
                check("tick_latency_edges", n, 3);
                check("ready_low_in_tick", lvl_ready, 1'b0);
            end
            @(posedge clk); #1;
            if (chk_timing) begin
                check("tick_width_one", frame_tick, 1'b0);
                check("ready_back_after_tick", lvl_ready, 1'b1);
            end
            check("snapshot", bar_y, exp);
            last_pub = exp;
        end
        VGA_VS = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        Reset = 1'b0;
        #1;
        check("rst_bar_y", bar_y, '0);
        check("rst_ready", lvl_ready, 1'b0);
        check("rst_tick", frame_tick, 1'b0);
        check("rst_bad_band", bad_band, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b1;
        model_clear();
        repeat (4) @(posedge clk);
        #1;
        check("ready_after_reset", lvl_ready, 1'b1);
    endtask

    initial begin
        int exp5;
        int n;
        bit seen;
        logic [NB*LW-1:0] exp;

        Reset     = 1'b0;
        lvl_valid = 1'b0;
        lvl_band  = '0;
        lvl_value = '0;
        VGA_VS    = 1'b1;

        vecs[0] = '{4'd3, 10'd200,  3, 10'd200, 10'd200};
        vecs[1] = '{4'd0, 10'd600,  0, 10'd479, 10'd479};
        vecs[2] = '{4'd0, 10'd100,  0, 10'd479, 10'd475};
        vecs[3] = '{4'd7, 10'd479,  7, 10'd479, 10'd479};
        vecs[4] = '{4'd9, 10'd1023, 9, 10'd479, 10'd479};
        vecs[5] = '{4'd3, 10'd150,  3, 10'd200, 10'd180};
        vecs[6] = '{4'd3, 10'd250,  3, 10'd250, 10'd250};
        vecs[7] = '{4'd1, 10'd0,    1, 10'd0,   10'd0};
        vecs[8] = '{4'd8, 10'd1,    8, 10'd1,   10'd1};

        @(posedge clk); #1;
        reset_dut();

        for (int i = 0; i < 9; i++) begin
            do_write(vecs[i].band, vecs[i].value);
            do_frame(i == 0);
`ifdef BAR_PEAK_HOLD_EN
            check($sformatf("vec%0d_bar%0d", i, vecs[i].chk_bar),
                  bar_y[vecs[i].chk_bar*LW +: LW], vecs[i].exp_hold);
`else
            check($sformatf("vec%0d_bar%0d", i, vecs[i].chk_bar),
                  bar_y[vecs[i].chk_bar*LW +: LW], vecs[i].exp_nohold);
`endif
        end

        // Peak hold / decay profile of a single bar over 27 frames
        reset_dut();
        do_write(4'd5, 10'd40);
        for (int k = 0; k < 27; k++) begin
            do_frame(1'b0);
`ifdef BAR_PEAK_HOLD_EN
            exp5 = (k < 16) ? 40 : 40 - 4 * (k - 15);
`else
            exp5 = 40 - 4 * k;
`endif
            if (exp5 < 0) exp5 = 0;
            check($sformatf("decay_frame%0d", k), bar_y[5*LW +: LW], LW'(exp5));
        end

        // Write raised during the tick cycle stays pending and lands the cycle after
        exp_q.push_back(model_pack());
        model_tick();
        VGA_VS = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            seen = frame_tick;
        end
        check("held_tick_seen", seen, 1'b1);
        lvl_valid = 1'b1;
        lvl_band  = 4'd2;
        lvl_value = 10'd300;
        check("held_ready_low", lvl_ready, 1'b0);
        exp = exp_q.pop_front();
        @(posedge clk); #1;
        check("held_ready_high", lvl_ready, 1'b1);
        check("held_snapshot", bar_y, exp);
        last_pub = exp;
        @(posedge clk); #1;
        model_write(2, 300);
        lvl_valid = 1'b0;
        VGA_VS = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        do_frame(1'b1);
        check("held_bar2", bar_y[2*LW +: LW], 10'd300);

        // Out-of-range band: accepted, discarded, sticky flag until reset
        do_write(4'd12, 10'd100);
        check("bad_band_set", bad_band, 1'b1);
        do_frame(1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("bad_band_sticky", bad_band, 1'b1);
        reset_dut();
        check("bad_band_cleared", bad_band, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
